sr_flag_bank: RTL and testbench

Parametrised bank of N independent set/reset flags for game-state tracking (collision, game-over, power-up, hazard-lane flags) between the input/collision logic and the display/scoring logic. Each channel is a clocked SR flag with a selectable conflict policy and an optional rising-edge-triggered input mode. The block also produces per-channel rise/fall pulses, sticky conflict indicators and an active-flag count. It replaces single-bit SR flops wherever groups of flags are managed together.

---
 rtl/sr_flag_bank_if.sv | 27 ++
 rtl/sr_flag_bank.sv | 88 ++++++++
 tb/tb_sr_flag_bank.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sr_flag_bank_if.sv
// Request/status bundle between game-state producers and the sr_flag_bank.
// The master drives the requests and the slave (the flag bank) returns the state.
interface sr_flag_bank_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N + 1);

  logic          clr;
  logic [N-1:0]  s;
  logic [N-1:0]  r;
  logic [N-1:0]  q;
  logic [N-1:0]  rose;
  logic [N-1:0]  fell;
  logic [N-1:0]  conflict;
  logic [CW-1:0] count;
  logic          any;

  modport master (
    output clr, s, r,
    input  q, rose, fell, conflict, count, any
  );

  modport slave (
    input  clr, s, r,
    output q, rose, fell, conflict, count, any
  );
endinterface

// File: rtl/sr_flag_bank.sv
// Bank of N clocked set/reset flags with a conflict policy, optional edge-triggered
// requests, registered rise/fall pulses, sticky conflict flags and an active count.
module sr_flag_bank #(
  parameter int           N    = 8,
  parameter int           MODE = 0,  // 0 set-wins, 1 reset-wins, 2 toggle, 3 hold
  parameter int           EDGE = 0,  // 1: requests act only on a 0->1 transition
  parameter logic [N-1:0] INIT = '0
) (
  input logic           clk,
  input logic           rst_n,
  sr_flag_bank_if.slave bus_if
);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  rose_q, rose_d;
  logic [N-1:0]  fell_q, fell_d;
  logic [N-1:0]  conflict_q, conflict_d;
  logic [N-1:0]  s_prev_q, r_prev_q;
  logic [N-1:0]  s_eff, r_eff, both, both_val, q_next;
  logic [CW-1:0] count;

  assign s_eff = (EDGE != 0) ? (bus_if.s & ~s_prev_q) : bus_if.s;
  assign r_eff = (EDGE != 0) ? (bus_if.r & ~r_prev_q) : bus_if.r;
  assign both  = s_eff & r_eff;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    both_val = q_q;
    case (MODE)
      0:       both_val = '1;
      1:       both_val = '0;
      2:       both_val = ~q_q;
      default: both_val = q_q;
    endcase
  end

  // Next state ignoring CLR; the pulses are derived from this value.
  assign q_next = (s_eff & ~r_eff) | (q_q & ~s_eff & ~r_eff) | (both & both_val);

  always_comb begin
    q_d        = q_next;
    rose_d     = q_next & ~q_q;
    fell_d     = ~q_next & q_q;
    conflict_d = conflict_q | both;
    if (bus_if.clr) begin
      q_d        = INIT;
      rose_d     = '0;
      fell_d     = '0;
      conflict_d = both;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= INIT;
      rose_q     <= '0;
      fell_q     <= '0;
      conflict_q <= '0;
      s_prev_q   <= '0;
      r_prev_q   <= '0;
    end else begin
      q_q        <= q_d;
      rose_q     <= rose_d;
      fell_q     <= fell_d;
      conflict_q <= conflict_d;
      s_prev_q   <= bus_if.s;
      r_prev_q   <= bus_if.r;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(q_q[i]);
    end
  end

  assign bus_if.q        = q_q;
  assign bus_if.rose     = rose_q;
  assign bus_if.fell     = fell_q;
  assign bus_if.conflict = conflict_q;
  assign bus_if.count    = count;
  assign bus_if.any      = |q_q;
endmodule

// File: tb/tb_sr_flag_bank.sv
// Drives six flag-bank configurations with one shared stimulus stream and compares
// every output against a rule-level reference model.
module tb_sr_flag_bank;
  localparam int ND = 6;

  function automatic int cfg_n(int g);
    return (g == 5) ? 7 : 4;
  endfunction
  function automatic int cfg_mode(int g);
    return (g < 4) ? g : ((g == 4) ? 0 : 2);
  endfunction
  function automatic int cfg_edge(int g);
    return (g >= 4) ? 1 : 0;
  endfunction
  function automatic int cfg_init(int g);
    return (g == 3 || g == 4) ? 5 : ((g == 5) ? 32'h55 : 0);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] st_s, st_r;
  logic        st_clr;

  logic [31:0] obs_q [ND];
  logic [31:0] obs_rose [ND];
  logic [31:0] obs_fell [ND];
  logic [31:0] obs_conf [ND];
  logic [31:0] obs_count [ND];
  logic [31:0] obs_any [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int NN = cfg_n(g);
    localparam logic [31:0] I32 = 32'(cfg_init(g));

    sr_flag_bank_if #(.N(NN)) dif ();

    sr_flag_bank #(
      .N(NN), .MODE(cfg_mode(g)), .EDGE(cfg_edge(g)), .INIT(I32[NN-1:0])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .bus_if(dif)
    );

    assign dif.clr      = st_clr;
    assign dif.s        = st_s[NN-1:0];
    assign dif.r        = st_r[NN-1:0];
    assign obs_q[g]     = 32'(dif.q);
    assign obs_rose[g]  = 32'(dif.rose);
    assign obs_fell[g]  = 32'(dif.fell);
    assign obs_conf[g]  = 32'(dif.conflict);
    assign obs_count[g] = 32'(dif.count);
    assign obs_any[g]   = 32'(dif.any);
  end

  int total = 0;
  int bad   = 0;

  // Reference model state, one entry per configuration.
  int unsigned mq [ND];
  int unsigned mrose [ND];
  int unsigned mfell [ND];
  int unsigned mconf [ND];
  int unsigned mps [ND];
  int unsigned mpr [ND];

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      mq[d] = cfg_init(d); mrose[d] = 0; mfell[d] = 0; mconf[d] = 0;
      mps[d] = 0; mpr[d] = 0;
    end
  endtask

  task automatic model_step(input int unsigned s, input int unsigned r, input bit clr);
    for (int d = 0; d < ND; d++) begin
      int unsigned m, sv, rv, se, re, nq;
      m  = (1 << cfg_n(d)) - 1;
      sv = s & m;
      rv = r & m;
      se = cfg_edge(d) ? (sv & ~mps[d]) : sv;
      re = cfg_edge(d) ? (rv & ~mpr[d]) : rv;
      nq = 0;
      for (int i = 0; i < cfg_n(d); i++) begin
        bit qi, si, ri, ni;
        qi = mq[d][i]; si = se[i]; ri = re[i];
        if (si && !ri)       ni = 1'b1;
        else if (!si && ri)  ni = 1'b0;
        else if (si && ri) begin
          case (cfg_mode(d))
            0:       ni = 1'b1;
            1:       ni = 1'b0;
            2:       ni = !qi;
            default: ni = qi;
          endcase
        end else             ni = qi;
        nq[i] = ni;
      end
      mrose[d] = clr ? 0 : (nq & ~mq[d] & m);
      mfell[d] = clr ? 0 : (~nq & mq[d] & m);
      mconf[d] = clr ? (se & re) : (mconf[d] | (se & re));
      mq[d]    = clr ? cfg_init(d) : nq;
      mps[d]   = sv;
      mpr[d]   = rv;
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      int unsigned pc;
      pc = 0;
      for (int i = 0; i < 32; i++) pc += mq[d][i];
      check("q", d, obs_q[d], mq[d]);
      check("rose", d, obs_rose[d], mrose[d]);
      check("fell", d, obs_fell[d], mfell[d]);
      check("conflict", d, obs_conf[d], mconf[d]);
      check("count", d, obs_count[d], pc);
      check("any", d, obs_any[d], (mq[d] != 0) ? 1 : 0);
    end
  endtask

  // Called away from the edge: drive, clock once, update the model, compare.
  task automatic step(input int unsigned s, input int unsigned r, input bit clr);
    st_s = s; st_r = r; st_clr = clr;
    @(posedge clk);
    model_step(s, r, clr);
    #1;
    compare_all();
  endtask

  task automatic async_reset(input int unsigned hold_s);
    rst_n = 1'b0;
    st_s = hold_s; st_r = 0; st_clr = 1'b0;
    model_reset();
    #1;
    compare_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int rises, falls;
    rst_n = 1'b0; st_s = 0; st_r = 0; st_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    check("reset_q", 0, obs_q[0], 32'h0);
    check("reset_q_init", 4, obs_q[4], 32'h5);
    rst_n = 1'b1;

    // Basic set / reset with pulses.
    step(32'h1, 0, 0);
    check("set_q", 0, obs_q[0], 32'h1);
    check("set_rose", 0, obs_rose[0], 32'h1);
    check("set_count", 0, obs_count[0], 32'd1);
    check("set_any", 0, obs_any[0], 32'd1);
    step(0, 0, 0);
    check("rose_one_cycle", 0, obs_rose[0], 32'h0);
    step(0, 32'h1, 0);
    check("reset_flag_q", 0, obs_q[0], 32'h0);
    check("reset_flag_fell", 0, obs_fell[0], 32'h1);
    step(0, 0, 0);

    // Conflict policies from a cleared bank.
    step(0, 0, 1);
    step(32'h2, 32'h2, 0);
    check("toggle_first_q", 2, obs_q[2], 32'h2);
    check("toggle_first_rose", 2, obs_rose[2], 32'h2);
    step(32'h2, 32'h2, 0);
    check("setwins_q", 0, obs_q[0], 32'h2);
    check("resetwins_q", 1, obs_q[1], 32'h0);
    check("toggle_second_q", 2, obs_q[2], 32'h0);
    check("toggle_second_fell", 2, obs_fell[2], 32'h2);
    check("hold_q_bit1", 3, obs_q[3] & 32'h2, 32'h0);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    for (int d = 0; d < 4; d++) check("conflict_sticky", d, obs_conf[d], 32'h2);
    step(0, 0, 1);
    for (int d = 0; d < 4; d++) check("conflict_clr", d, obs_conf[d], 32'h0);

    // Edge mode: S held, R pulsed on the third cycle.
    rises = 0; falls = 0;
    for (int k = 0; k < 6; k++) begin
      step(32'h8, (k == 2) ? 32'h8 : 0, 0);
      if (k == 0) check("edge_set_q3", 4, obs_q[4] & 32'h8, 32'h8);
      rises += obs_rose[4][3];
      falls += obs_fell[4][3];
    end
    check("edge_q3_low", 4, obs_q[4] & 32'h8, 32'h0);
    check("edge_rose_once", 4, 32'(rises), 32'd1);
    check("edge_fell_once", 4, 32'(falls), 32'd1);
    step(0, 0, 0);

    // CLR behaviour with INIT=0101 on a level-mode bank.
    step(32'hA, 32'h5, 0);
    check("pre_clr_q", 3, obs_q[3], 32'hA);
    step(32'hF, 0, 1);
    check("clr_q", 3, obs_q[3], 32'h5);
    check("clr_rose", 3, obs_rose[3], 32'h0);
    check("clr_fell", 3, obs_fell[3], 32'h0);
    step(32'hF, 0, 0);
    check("post_clr_q", 3, obs_q[3], 32'hF);
    check("post_clr_rose", 3, obs_rose[3], 32'hA);

    // Asynchronous reset mid-pulse, S held high through release.
    async_reset(32'h7F);
    check("arst_q", 3, obs_q[3], 32'h5);
    check("arst_rose", 3, obs_rose[3], 32'h0);
    check("arst_conflict", 3, obs_conf[3], 32'h0);
    step(32'h7F, 0, 0);
    check("release_edge_q", 4, obs_q[4], 32'hF);
    check("count7_q", 5, obs_q[5], 32'h7F);
    check("count7", 5, obs_count[5], 32'd7);
    check("count7_any", 5, obs_any[5], 32'd1);
    step(0, 32'h1, 0);
    check("count6", 5, obs_count[5], 32'd6);

    // Randomised traffic with occasional CLR and asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(63) == 0) async_reset($urandom);
      else step($urandom & $urandom, $urandom & $urandom, $urandom_range(15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
